snes_bus_responder: RTL and testbench

- Cartridge-side responder for SNES CPU B/A-bus accesses to the SuperFX register window.
- Synchronises the asynchronous /RD and /WR strobes into the mck domain and decodes the 24-bit CPU address.
- Issues single-beat register read/write requests to the SuperFX core and drives the cartridge data bus for reads.
- Sits between the slot-level pin wrapper and the SuperFX core; also owns the open-drain /IRQ drive.

---
 rtl/snes_bus_responder_pkg.sv | 26 ++
 rtl/snes_bus_responder_if.sv | 19 +
 rtl/snes_bus_responder_sync.sv | 33 +++
 rtl/snes_bus_responder.sv | 170 +++++++++++++++++
 tb/tb_snes_bus_responder.sv | 362 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/snes_bus_responder_pkg.sv
// Shared types and constants for the SuperFX register-window bus responder.
package snes_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_DRIVE,
    ST_WR_CAPT,
    ST_WR_REQ
  } state_t;

  localparam logic [15:0] REG_BASE_DEF = 16'h3000;
  localparam logic [15:0] REG_LAST_DEF = 16'h32FF;

  // Bit 22 set means banks $40-7F / $C0-FF, which never map the register window.
  localparam logic [23:0] BANK_MASK = 24'h40_0000;

  localparam logic [7:0] OPEN_BUS = 8'hFF;

  function automatic logic reg_hit(input logic [23:0] addr, input logic romsel_n,
                                   input logic [15:0] base, input logic [15:0] last);
    return romsel_n && ((addr & BANK_MASK) == 24'h0) &&
           (addr[15:0] >= base) && (addr[15:0] <= last);
  endfunction

endpackage

// File: rtl/snes_bus_responder_if.sv
// Single-outstanding register request channel between the bus responder and the SuperFX core.
interface snes_bus_responder_if;
  logic [9:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_wr_req;
  logic       reg_rd_req;
  logic       reg_ack;
  logic [7:0] reg_rdata;

  modport master (
    output reg_addr, reg_wdata, reg_wr_req, reg_rd_req,
    input  reg_ack, reg_rdata
  );

  modport slave (
    input  reg_addr, reg_wdata, reg_wr_req, reg_rd_req,
    output reg_ack, reg_rdata
  );
endinterface

// File: rtl/snes_bus_responder_sync.sv
// STAGES-deep synchroniser for an active-low strobe, with falling/rising edge flags
// aligned to the synchronised level.
module snes_sync #(
  parameter int STAGES = 2
) (
  input  logic mck,
  input  logic reset,
  input  logic din,
  output logic dout,
  output logic fall,
  output logic rise
);

  logic [STAGES-1:0] sr;
  logic              prev;

  // NOTE: flops reset to the idle (high) level so reset release never fakes a strobe edge;
  // all state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge mck or posedge reset) begin
    if (reset) begin
      sr   <= '1;
      prev <= 1'b1;
    end else begin
      sr   <= {sr[STAGES-2:0], din};
      prev <= sr[STAGES-1];
    end
  end

  assign dout = sr[STAGES-1];
  assign fall = prev & ~dout;
  assign rise = ~prev & dout;

endmodule

// File: rtl/snes_bus_responder.sv
// SNES cartridge-side responder for the SuperFX register window.
// Optional ack timeout with sticky bus_err: define SNES_BUS_TIMEOUT_EN.
module snes_bus_responder
  import snes_bus_pkg::*;
#(
  parameter logic [15:0] REG_BASE    = REG_BASE_DEF,
  parameter logic [15:0] REG_LAST    = REG_LAST_DEF,
  parameter int          SYNC_STAGES = 2,
  parameter int          TIMEOUT     = 8
) (
  input  logic                        mck,
  input  logic                        reset,
  input  logic [23:0]                 ca,
  input  logic [7:0]                  d_in,
  input  logic                        cpurd_n,
  input  logic                        cpuwr_n,
  input  logic                        romsel_n,
  output logic [7:0]                  d_out,
  output logic                        d_oe,
  output logic                        irq_oe,
  snes_bus_responder_if.master        regs,
  input  logic                        core_irq,
  output logic                        bus_err
);

  if (SYNC_STAGES < 2 || TIMEOUT < 1) begin : g_param_check
    $error("snes_bus_responder: SYNC_STAGES must be >= 2 and TIMEOUT >= 1");
  end

  logic rd_s, rd_fall, rd_rise;
  logic wr_s, wr_fall, wr_rise;

  snes_sync #(.STAGES(SYNC_STAGES)) u_rd_sync (
    .mck(mck), .reset(reset), .din(cpurd_n), .dout(rd_s), .fall(rd_fall), .rise(rd_rise)
  );

  snes_sync #(.STAGES(SYNC_STAGES)) u_wr_sync (
    .mck(mck), .reset(reset), .din(cpuwr_n), .dout(wr_s), .fall(wr_fall), .rise(wr_rise)
  );

  // Address, data and select ride the same depth as the strobes so they line up with the edges.
  logic [SYNC_STAGES-1:0][23:0] ca_sr;
  logic [SYNC_STAGES-1:0][7:0]  d_sr;
  logic [SYNC_STAGES-1:0]       romsel_sr;

  always_ff @(posedge mck or posedge reset) begin
    if (reset) begin
      ca_sr     <= '0;
      d_sr      <= '0;
      romsel_sr <= '1;
    end else begin
      ca_sr     <= {ca_sr[SYNC_STAGES-2:0], ca};
      d_sr      <= {d_sr[SYNC_STAGES-2:0], d_in};
      romsel_sr <= {romsel_sr[SYNC_STAGES-2:0], romsel_n};
    end
  end

  logic [23:0] ca_s;
  logic [7:0]  d_s;
  logic        hit;
  logic [9:0]  offset;

  assign ca_s   = ca_sr[SYNC_STAGES-1];
  assign d_s    = d_sr[SYNC_STAGES-1];
  assign hit    = reg_hit(ca_s, romsel_sr[SYNC_STAGES-1], REG_BASE, REG_LAST);
  assign offset = 10'(ca_s[15:0] - REG_BASE);

  state_t state;
  logic   rd_abort;
  logic   tmo;

`ifdef SNES_BUS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] tmo_cnt;
  logic             in_req;

  assign in_req = (state == ST_RD_REQ) || (state == ST_WR_REQ);
  assign tmo    = in_req && !regs.reg_ack && (tmo_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge mck or posedge reset) begin
    if (reset) begin
      tmo_cnt <= '0;
      bus_err <= 1'b0;
    end else begin
      tmo_cnt <= in_req ? tmo_cnt + 1'b1 : '0;
      if (tmo) bus_err <= 1'b1;
    end
  end
`else
  assign tmo     = 1'b0;
  assign bus_err = 1'b0;
`endif

  always_ff @(posedge mck or posedge reset) begin
    if (reset) begin
      state           <= ST_IDLE;
      rd_abort        <= 1'b0;
      d_out           <= '0;
      d_oe            <= 1'b0;
      regs.reg_addr   <= '0;
      regs.reg_wdata  <= '0;
      regs.reg_wr_req <= 1'b0;
      regs.reg_rd_req <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          rd_abort <= 1'b0;
          // Read wins a simultaneous edge; the write is simply never started.
          if (rd_fall && hit) begin
            regs.reg_addr   <= offset;
            regs.reg_rd_req <= 1'b1;
            state           <= ST_RD_REQ;
          end else if (wr_fall && hit) begin
            regs.reg_addr  <= offset;
            regs.reg_wdata <= d_s;
            state          <= ST_WR_CAPT;
          end
        end

        ST_RD_REQ: begin
          if (rd_rise) rd_abort <= 1'b1;
          if (regs.reg_ack || tmo) begin
            regs.reg_rd_req <= 1'b0;
            if (rd_abort || rd_rise) begin
              state <= ST_IDLE;
            end else begin
              d_out <= regs.reg_ack ? regs.reg_rdata : OPEN_BUS;
              d_oe  <= 1'b1;
              state <= ST_RD_DRIVE;
            end
          end
        end

        ST_RD_DRIVE: begin
          if (rd_s) begin
            d_oe  <= 1'b0;
            state <= ST_IDLE;
          end
        end

        ST_WR_CAPT: begin
          // Keep reloading while the strobe is low so the last pre-rise value is the one issued.
          if (wr_rise || wr_s) begin
            regs.reg_wr_req <= 1'b1;
            state           <= ST_WR_REQ;
          end else begin
            regs.reg_addr  <= offset;
            regs.reg_wdata <= d_s;
          end
        end

        ST_WR_REQ: begin
          if (regs.reg_ack || tmo) begin
            regs.reg_wr_req <= 1'b0;
            state           <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge mck or posedge reset) begin
    if (reset) irq_oe <= 1'b0;
    else       irq_oe <= core_irq;
  end

endmodule

// File: tb/tb_snes_bus_responder.sv
// Self-checking bench for snes_bus_responder: vector table plus directed multi-cycle sequences,
// with a request scoreboard fed by the stimulus and drained by a request monitor.
module tb_snes_bus_responder;

  localparam int SYNC = 2;
  localparam int TMO  = 8;

  logic        mck = 1'b0;
  logic        reset;
  logic [23:0] ca;
  logic [7:0]  d_in;
  logic        cpurd_n;
  logic        cpuwr_n;
  logic        romsel_n;
  logic [7:0]  d_out;
  logic        d_oe;
  logic        irq_oe;
  logic        core_irq;
  logic        bus_err;

  snes_bus_responder_if bus ();

  snes_bus_responder #(
    .REG_BASE(16'h3000), .REG_LAST(16'h32FF), .SYNC_STAGES(SYNC), .TIMEOUT(TMO)
  ) dut (
    .mck(mck), .reset(reset), .ca(ca), .d_in(d_in), .cpurd_n(cpurd_n), .cpuwr_n(cpuwr_n),
    .romsel_n(romsel_n), .d_out(d_out), .d_oe(d_oe), .irq_oe(irq_oe), .regs(bus),
    .core_irq(core_irq), .bus_err(bus_err)
  );

  always #5 mck = ~mck;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit         wr;
    logic [9:0] addr;
    logic [7:0] wdata;
  } exp_t;

  exp_t exp_q[$];

  task automatic push_exp(input bit wr, input logic [23:0] a, input logic [7:0] wd);
    exp_t e;
    logic [15:0] rel;
    rel     = a[15:0] - 16'h3000;
    e.wr    = wr;
    e.addr  = rel[9:0];
    e.wdata = wd;
    exp_q.push_back(e);
  endtask

  // Core model: acks ack_delay negedges after a request is first seen.
  bit         ack_en    = 1'b1;
  int         ack_delay = 1;
  logic [7:0] rdata_next = 8'h00;

  initial begin
    int wait_cnt;
    wait_cnt      = 0;
    bus.reg_ack   = 1'b0;
    bus.reg_rdata = 8'h00;
    forever begin
      @(negedge mck);
      bus.reg_ack = 1'b0;
      if (ack_en && (bus.reg_rd_req || bus.reg_wr_req)) begin
        if (wait_cnt >= ack_delay) begin
          bus.reg_ack   = 1'b1;
          bus.reg_rdata = rdata_next;
          wait_cnt      = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Request monitor: every new request must match the head of the scoreboard.
  initial begin
    bit   prev_rd, prev_wr;
    exp_t e;
    prev_rd = 1'b0;
    prev_wr = 1'b0;
    forever begin
      @(negedge mck);
      if (!reset && ((bus.reg_rd_req && !prev_rd) || (bus.reg_wr_req && !prev_wr))) begin
        check("req_exclusive", 32'(bus.reg_rd_req & bus.reg_wr_req), 0);
        check("req_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("req_kind", 32'(bus.reg_wr_req), 32'(e.wr));
          check("req_addr", 32'(bus.reg_addr), 32'(e.addr));
          if (e.wr) begin
            check("req_wdata", 32'(bus.reg_wdata), 32'(e.wdata));
            check("wr_after_rise", 32'(cpuwr_n), 1);
          end
        end
      end
      prev_rd = bus.reg_rd_req;
      prev_wr = bus.reg_wr_req;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic access(input logic [23:0] a, input logic rsel, input bit rd, input bit wr,
                        input logic [7:0] data, output bit oe_seen, output logic [7:0] oe_data);
    @(negedge mck);
    ca         = a;
    romsel_n   = rsel;
    d_in       = data;
    rdata_next = data;
    @(negedge mck);
    cpurd_n = !rd;
    cpuwr_n = !wr;
    oe_seen = 1'b0;
    oe_data = 8'h00;
    repeat (12) begin
      @(negedge mck);
      if (d_oe && !oe_seen) begin
        oe_seen = 1'b1;
        oe_data = d_out;
      end
    end
    cpurd_n = 1'b1;
    cpuwr_n = 1'b1;
    repeat (10) @(negedge mck);
    romsel_n = 1'b1;
  endtask

  task automatic wait_rd_req(output int lat);
    lat = 0;
    for (int i = 1; i <= 16 && lat == 0; i++) begin
      @(negedge mck);
      if (bus.reg_rd_req) lat = i;
    end
  endtask

  typedef struct {
    logic [23:0] ca;
    logic        romsel_n;
    bit          rd;
    bit          wr;
    logic [7:0]  data;
    bit          hit;
  } vec_t;

  initial begin
    vec_t       vecs[11];
    bit         seen;
    logic [7:0] odata;
    int         lat, lat2, hold;

    vecs[0]  = '{24'h8031FF, 1'b1, 1'b0, 1'b1, 8'hC3, 1'b1};
    vecs[1]  = '{24'h403000, 1'b1, 1'b1, 1'b0, 8'h11, 1'b0};
    vecs[2]  = '{24'h003300, 1'b1, 1'b1, 1'b0, 8'h22, 1'b0};
    vecs[3]  = '{24'h003000, 1'b0, 1'b1, 1'b0, 8'h33, 1'b0};
    vecs[4]  = '{24'h003000, 1'b1, 1'b1, 1'b1, 8'h77, 1'b1};
    vecs[5]  = '{24'h3F32FF, 1'b1, 1'b1, 1'b0, 8'hA5, 1'b1};
    vecs[6]  = '{24'hC03000, 1'b1, 1'b1, 1'b0, 8'h44, 1'b0};
    vecs[7]  = '{24'h002FFF, 1'b1, 1'b0, 1'b1, 8'h55, 1'b0};
    vecs[8]  = '{24'h803000, 1'b1, 1'b0, 1'b1, 8'h3C, 1'b1};
    vecs[9]  = '{24'h003100, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1};
    vecs[10] = '{24'h7F3010, 1'b1, 1'b0, 1'b1, 8'h66, 1'b0};

    reset    = 1'b1;
    ca       = '0;
    d_in     = '0;
    cpurd_n  = 1'b1;
    cpuwr_n  = 1'b1;
    romsel_n = 1'b1;
    core_irq = 1'b0;
    repeat (3) @(negedge mck);

    check("rst_d_out",  32'(d_out), 0);
    check("rst_d_oe",   32'(d_oe), 0);
    check("rst_irq_oe", 32'(irq_oe), 0);
    check("rst_addr",   32'(bus.reg_addr), 0);
    check("rst_wdata",  32'(bus.reg_wdata), 0);
    check("rst_wr_req", 32'(bus.reg_wr_req), 0);
    check("rst_rd_req", 32'(bus.reg_rd_req), 0);
    check("rst_bus_err", 32'(bus_err), 0);
    reset = 1'b0;
    repeat (2) @(negedge mck);

    // Directed read with latency and release timing.
    ca         = 24'h003030;
    rdata_next = 8'h5A;
    push_exp(1'b0, 24'h003030, 8'h00);
    @(negedge mck);
    cpurd_n = 1'b0;
    wait_rd_req(lat);
    check("rd_req_latency", 32'(lat), 32'(SYNC + 1));
    lat2 = 0;
    for (int i = 1; i <= 16 && lat2 == 0; i++) begin
      @(negedge mck);
      if (d_oe) lat2 = i;
    end
    check("d_oe_after_req", 32'(lat2), 2);
    check("rd_data", 32'(d_out), 32'h5A);
    check("rd_req_dropped", 32'(bus.reg_rd_req), 0);
    repeat (4) @(negedge mck);
    check("d_oe_held", 32'(d_oe), 1);
    cpurd_n = 1'b1;
    hold = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge mck);
      if (d_oe) hold++;
    end
    check("d_oe_release_cycles", 32'(hold), 32'(SYNC));
    repeat (4) @(negedge mck);

    // Vector table: hits, misses, window boundaries and the simultaneous-edge case.
    for (int i = 0; i < 11; i++) begin
      if (vecs[i].hit) push_exp(!vecs[i].rd, vecs[i].ca, vecs[i].data);
      access(vecs[i].ca, vecs[i].romsel_n, vecs[i].rd, vecs[i].wr, vecs[i].data, seen, odata);
      check($sformatf("vec%0d_oe", i), 32'(seen), 32'(vecs[i].hit && vecs[i].rd));
      if (vecs[i].hit && vecs[i].rd) check($sformatf("vec%0d_rdata", i), 32'(odata), 32'(vecs[i].data));
      check($sformatf("vec%0d_idle", i), 32'({d_oe, bus.reg_rd_req, bus.reg_wr_req}), 0);
    end

    // Read aborted by an early rd rise: ack arrives late, data is dropped, d_oe never asserts.
    ack_en = 1'b0;
    ca     = 24'h003010;
    push_exp(1'b0, 24'h003010, 8'h00);
    @(negedge mck);
    cpurd_n = 1'b0;
    wait_rd_req(lat);
    check("abort_req_seen", 32'(lat != 0), 1);
    cpurd_n = 1'b1;
    seen = 1'b0;
    repeat (3) begin
      @(negedge mck);
      if (d_oe) seen = 1'b1;
    end
    ack_en = 1'b1;
    repeat (10) begin
      @(negedge mck);
      if (d_oe) seen = 1'b1;
    end
    check("abort_no_oe", 32'(seen), 0);
    check("abort_req_done", 32'(bus.reg_rd_req), 0);
    check("abort_no_err", 32'(bus_err), 0);
    push_exp(1'b0, 24'h003020, 8'h00);
    access(24'h003020, 1'b1, 1'b1, 1'b0, 8'h42, seen, odata);
    check("after_abort_oe", 32'(seen), 1);
    check("after_abort_data", 32'(odata), 32'h42);

    // Reset while driving the bus.
    push_exp(1'b0, 24'h003000, 8'h00);
    ca         = 24'h003000;
    rdata_next = 8'h99;
    @(negedge mck);
    cpurd_n = 1'b0;
    lat = 0;
    for (int i = 1; i <= 16 && lat == 0; i++) begin
      @(negedge mck);
      if (d_oe) lat = i;
    end
    check("pre_reset_drive", 32'(lat != 0), 1);
    reset = 1'b1;
    #1;
    check("reset_d_oe", 32'(d_oe), 0);
    check("reset_reqs", 32'({bus.reg_rd_req, bus.reg_wr_req}), 0);
    check("reset_d_out", 32'(d_out), 0);
    cpurd_n = 1'b1;
    repeat (3) @(negedge mck);
    reset = 1'b0;
    repeat (2) @(negedge mck);
    push_exp(1'b1, 24'h003123, 8'hE7);
    access(24'h003123, 1'b1, 1'b0, 1'b1, 8'hE7, seen, odata);
    check("post_reset_wr_no_oe", 32'(seen), 0);
    push_exp(1'b0, 24'h0032FE, 8'h00);
    access(24'h0032FE, 1'b1, 1'b1, 1'b0, 8'hB4, seen, odata);
    check("post_reset_rd_data", 32'(odata), 32'hB4);

`ifdef SNES_BUS_TIMEOUT_EN
    // No ack: after TMO cycles the open-bus value is driven and bus_err sticks.
    ack_en = 1'b0;
    ca     = 24'h003040;
    push_exp(1'b0, 24'h003040, 8'h00);
    @(negedge mck);
    cpurd_n = 1'b0;
    wait_rd_req(lat);
    lat2 = 0;
    for (int i = 1; i <= 20 && lat2 == 0; i++) begin
      @(negedge mck);
      if (d_oe) lat2 = i;
    end
    check("tmo_cycles", 32'(lat2), 32'(TMO));
    check("tmo_d_out", 32'(d_out), 32'hFF);
    check("tmo_bus_err", 32'(bus_err), 1);
    check("tmo_req_dropped", 32'(bus.reg_rd_req), 0);
    cpurd_n = 1'b1;
    repeat (6) @(negedge mck);
    ack_en = 1'b1;
    check("tmo_released", 32'(d_oe), 0);
    push_exp(1'b0, 24'h003041, 8'h00);
    access(24'h003041, 1'b1, 1'b1, 1'b0, 8'h3E, seen, odata);
    check("tmo_next_data", 32'(odata), 32'h3E);
    check("tmo_err_sticky", 32'(bus_err), 1);
`else
    // No ack: the request waits indefinitely with no error flag.
    ack_en = 1'b0;
    ca     = 24'h003040;
    push_exp(1'b0, 24'h003040, 8'h00);
    @(negedge mck);
    cpurd_n = 1'b0;
    wait_rd_req(lat);
    seen = 1'b0;
    repeat (20) begin
      @(negedge mck);
      if (d_oe) seen = 1'b1;
    end
    check("wait_req_held", 32'(bus.reg_rd_req), 1);
    check("wait_no_oe", 32'(seen), 0);
    check("wait_no_err", 32'(bus_err), 0);
    cpurd_n = 1'b1;
    repeat (3) @(negedge mck);
    ack_en = 1'b1;
    repeat (8) begin
      @(negedge mck);
      if (d_oe) seen = 1'b1;
    end
    check("wait_req_done", 32'(bus.reg_rd_req), 0);
    check("wait_aborted_no_oe", 32'(seen), 0);
`endif

    // IRQ pass-through with one cycle of latency.
    @(negedge mck);
    core_irq = 1'b1;
    #1;
    check("irq_not_yet", 32'(irq_oe), 0);
    @(negedge mck);
    check("irq_set", 32'(irq_oe), 1);
    core_irq = 1'b0;
    @(negedge mck);
    check("irq_clear", 32'(irq_oe), 0);

    repeat (4) @(negedge mck);
    check("scoreboard_empty", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
